// File: rtl/nn_loader.sv
// Stream loader for the nn_node stage: collects features and weights word by word,
// then presents the completed frame until nn_node signals a fresh result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// LOAD    | accepting stream words into x_bus / w_hid / w_out
// PRESENT | frame frozen and offered to nn_node, waiting for out_ready rise
module nn_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         w_keep,
    output logic [63:0]  x_bus,
    output logic [255:0] w_hid,
    output logic [127:0] w_out,
    output logic         in_ready,
    input  logic         out_ready,
    output logic         frame_done,
    output logic [7:0]   frame_cnt
);

    typedef enum logic {LOAD = 1'b0, PRESENT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q;
    logic        short_q;
    logic        wt_valid_q;
    logic        out_ready_q;
    logic        accept;
    logic        short_now;
    logic        last_word;
    logic        present_exit;

    assign accept       = s_valid && s_ready;
    // Frame length is decided by w_keep on the first word and then held for the frame.
    assign short_now    = (idx_q == 5'd0) ? (w_keep && wt_valid_q) : short_q;
    assign last_word    = accept && (idx_q == (short_now ? 5'd3 : 5'd27));
    // Only a fresh rising edge ends PRESENT; a level left over from the last frame does not.
    assign present_exit = (state_q == PRESENT) && out_ready && !out_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (last_word)    state_d = PRESENT;
            PRESENT: if (present_exit) state_d = LOAD;
            default:                   state_d = LOAD;
        endcase
    end

    always_comb begin
        s_ready  = (state_q == LOAD) && !rst;
        in_ready = (state_q == PRESENT) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 5'd0;
            short_q     <= 1'b0;
            wt_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
            x_bus       <= '0;
            w_hid       <= '0;
            w_out       <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            out_ready_q <= out_ready;
            frame_done  <= present_exit;
            if (present_exit) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (accept) begin
                if (idx_q == 5'd0) begin
                    short_q <= w_keep && wt_valid_q;
                end
                if (idx_q == 5'd27) begin
                    wt_valid_q <= 1'b1;
                end
                idx_q <= last_word ? 5'd0 : idx_q + 5'd1;
                for (int k = 0; k < 4; k++) begin
                    if (idx_q == 5'(k)) x_bus[16*k +: 16] <= s_data;
                end
                for (int k = 0; k < 16; k++) begin
                    if (idx_q == 5'(k + 4)) w_hid[16*k +: 16] <= s_data;
                end
                for (int k = 0; k < 8; k++) begin
                    if (idx_q == 5'(k + 20)) w_out[16*k +: 16] <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_nn_loader.sv
// Directed bench for nn_loader: full and weight-reuse frames, stalls, stale
// out_ready, resets mid-load and mid-present, and frame counter wrap.
`timescale 1ns/1ps
module tb_nn_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic         w_keep;
    logic [63:0]  x_bus;
    logic [255:0] w_hid;
    logic [127:0] w_out;
    logic         in_ready;
    logic         out_ready;
    logic         frame_done;
    logic [7:0]   frame_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int fd_pulses = 0;
    int fd_base;

    nn_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .w_keep     (w_keep),
        .x_bus      (x_bus),
        .w_hid      (w_hid),
        .w_out      (w_out),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        k;
        logic        o;
        logic        e_sr;
        logic        e_ir;
        logic        e_fd;
        logic [7:0]  e_cnt;
        logic [63:0] e_x;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic v, logic [15:0] d, logic k, logic o,
                                logic e_sr, logic e_ir, logic e_fd,
                                logic [7:0] e_cnt, logic [63:0] e_x);
        vec_t r;
        r.v = v; r.d = d; r.k = k; r.o = o;
        r.e_sr = e_sr; r.e_ir = e_ir; r.e_fd = e_fd; r.e_cnt = e_cnt; r.e_x = e_x;
        return r;
    endfunction

    function automatic logic [15:0] word_of(int set, int k);
        if (set == 1) begin
            case (k)
                0:  return 16'd4;
                1:  return 16'd2;
                2:  return 16'd4;
                3:  return 16'd1;
                4:  return 16'd3;
                5:  return 16'd2;
                6:  return 16'd13;
                27: return 16'd6;
                default: return 16'h0100 + 16'(k);
            endcase
        end
        return 16'h2000 + 16'(k * 5);
    endfunction

    function automatic logic [63:0] x_of(int set);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = word_of(set, i);
        return r;
    endfunction

    function automatic logic [255:0] hid_of(int set);
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = word_of(set, i + 4);
        return r;
    endfunction

    function automatic logic [127:0] out_of(int set);
        logic [127:0] r = '0;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = word_of(set, i + 20);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_range(input int set, input int from, input int to, input logic keep);
        for (int i = from; i <= to; i++) begin
            s_valid = 1'b1;
            s_data  = word_of(set, i);
            w_keep  = (i == from) ? keep : 1'b0;
            step();
        end
        s_valid = 1'b0;
        w_keep  = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        step();
    endtask

    localparam logic [63:0] X0 = 64'h0001_0004_0002_0004;
    localparam logic [63:0] XA = 64'h0001_0004_0002_0007;
    localparam logic [63:0] XB = 64'h0001_0004_0007_0007;
    localparam logic [63:0] XC = 64'h0001_0007_0007_0007;
    localparam logic [63:0] X7 = 64'h0007_0007_0007_0007;

    initial begin
        // weight-reuse frame with stall, ignored words in PRESENT and stale out_ready
        tbl[0]  = mk(1'b1, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, X0);
        tbl[1]  = mk(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, XA);
        tbl[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, XB);
        tbl[3]  = mk(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, XB);
        tbl[4]  = mk(1'b1, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, XC);
        tbl[5]  = mk(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, X7);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, X7);
        tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, X7);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, X7);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, X7);
        tbl[10] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, X7);

        rst = 1'b1; s_data = '0; s_valid = 1'b0; w_keep = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("rst.s_ready", s_ready, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.x_bus", x_bus, 0);
        chk("rst.w_hid", w_hid, 0);
        chk("rst.w_out", w_out, 0);
        chk("rst.frame_done", frame_done, 0);
        chk("rst.frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        #1;
        chk("post_rst.s_ready", s_ready, 1);

        // w_keep without stored weights still needs all 28 words
        load_range(1, 0, 3, 1'b1);
        chk("keep_no_wt.in_ready", in_ready, 0);
        chk("keep_no_wt.s_ready", s_ready, 1);
        load_range(1, 4, 27, 1'b0);
        chk("full.in_ready", in_ready, 1);
        chk("full.s_ready", s_ready, 0);
        chk("full.x_bus", x_bus, X0);
        chk("full.w04", w_hid[15:0], 3);
        chk("full.w79", w_out[127:112], 6);
        chk("full.w_hid", w_hid, hid_of(1));
        chk("full.w_out", w_out, out_of(1));

        s_valid = 1'b1; s_data = 16'hffff;
        for (int i = 0; i < 3; i++) step();
        s_valid = 1'b0;
        chk("present_hold.x_bus", x_bus, X0);
        chk("present_hold.w_hid", w_hid, hid_of(1));
        chk("present_hold.in_ready", in_ready, 1);

        handoff();
        chk("handoff.frame_done", frame_done, 1);
        chk("handoff.frame_cnt", frame_cnt, 1);
        chk("handoff.in_ready", in_ready, 0);
        chk("handoff.s_ready", s_ready, 1);

        for (int i = 0; i < 11; i++) begin
            s_valid   = tbl[i].v;
            s_data    = tbl[i].d;
            w_keep    = tbl[i].k;
            out_ready = tbl[i].o;
            chk($sformatf("tbl[%0d].s_ready", i), s_ready, tbl[i].e_sr);
            chk($sformatf("tbl[%0d].in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("tbl[%0d].frame_done", i), frame_done, tbl[i].e_fd);
            chk($sformatf("tbl[%0d].frame_cnt", i), frame_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl[%0d].x_bus", i), x_bus, tbl[i].e_x);
            step();
        end
        s_valid = 1'b0; w_keep = 1'b0;
        chk("reuse.w_hid", w_hid, hid_of(1));
        chk("reuse.w_out", w_out, out_of(1));

        // reset in the middle of a load, then a clean frame from a different word set
        load_range(1, 0, 9, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_load.s_ready_comb", s_ready, 0);
        step();
        chk("rst_load.x_bus", x_bus, 0);
        chk("rst_load.w_hid", w_hid, 0);
        chk("rst_load.w_out", w_out, 0);
        chk("rst_load.frame_cnt", frame_cnt, 0);
        chk("rst_load.in_ready", in_ready, 0);
        rst = 1'b0;
        load_range(2, 0, 3, 1'b1);
        chk("reload.short_blocked", in_ready, 0);
        load_range(2, 4, 27, 1'b0);
        chk("reload.in_ready", in_ready, 1);
        chk("reload.x_bus", x_bus, x_of(2));
        chk("reload.w_hid", w_hid, hid_of(2));
        chk("reload.w_out", w_out, out_of(2));

        // reset while presenting aborts the handoff
        out_ready = 1'b0;
        step();
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_present.in_ready", in_ready, 0);
        chk("rst_present.frame_done", frame_done, 0);
        chk("rst_present.frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        out_ready = 1'b0;
        step();
        chk("rst_present.frame_done2", frame_done, 0);
        chk("rst_present.frame_cnt2", frame_cnt, 0);
        chk("rst_present.s_ready", s_ready, 1);

        // 256 frames: one full, then weight-reuse frames
        fd_base = fd_pulses;
        load_range(1, 0, 27, 1'b0);
        handoff();
        for (int f = 1; f < 256; f++) begin
            load_range(1, 0, 3, 1'b1);
            handoff();
            if (f == 254) chk("wrap.cnt255", frame_cnt, 255);
        end
        chk("wrap.frame_cnt", frame_cnt, 0);
        step();
        chk("wrap.pulses", fd_pulses - fd_base, 256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
